// File: rtl/music_notes_gen.sv
// Square-wave tone generator. Eight DIP switches pick one note of the C4..C5 major
// scale; the speaker pin toggles at that note's pitch with a 50 % duty cycle.
//
// Parameters:
//   CLK_HZ        input clock frequency in Hz
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   dip_switches  note select (bit0 = C4 ... bit7 = C5), asynchronous to clk
//   speaker       registered square-wave output
//
// Selection is taken from a 2-flop synchronizer. The lowest-index set bit wins and
// all-zero means silent. Any change of the selected note (including to/from silent)
// restarts the tone from phase 0 with the speaker low, so no truncated half-period
// of the old note is ever emitted.

module music_notes_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dip_switches,
  output logic       speaker
);

  // Half-period lengths in clk cycles, floor(CLK_HZ / (2 * f)).
  localparam int unsigned Half0 = CLK_HZ / (2 * 262);
  localparam int unsigned Half1 = CLK_HZ / (2 * 294);
  localparam int unsigned Half2 = CLK_HZ / (2 * 330);
  localparam int unsigned Half3 = CLK_HZ / (2 * 349);
  localparam int unsigned Half4 = CLK_HZ / (2 * 392);
  localparam int unsigned Half5 = CLK_HZ / (2 * 440);
  localparam int unsigned Half6 = CLK_HZ / (2 * 494);
  localparam int unsigned Half7 = CLK_HZ / (2 * 523);

  // C4 has the longest half-period, so it sizes the counter.
  localparam int unsigned CntW = $clog2(Half0 + 1);

  logic [7:0]      sync1_q, sync2_q;
  logic            cur_valid;
  logic [2:0]      cur_idx;
  logic            sel_valid_q;
  logic [2:0]      sel_idx_q;
  logic            sel_change;
  logic [CntW-1:0] half_m1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            speaker_q, speaker_d;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= dip_switches;
      sync2_q <= sync1_q;
    end
  end

  // Fixed-priority encoder: lowest-index set bit wins.
  always_comb begin
    cur_valid = |sync2_q;
    cur_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sync2_q[i]) begin
        cur_idx = 3'(i);
      end
    end
  end

  // A change is detected on the first cycle the synchronized selection differs from
  // the one currently playing. Index is irrelevant while silent.
  always_comb begin
    sel_change = (cur_valid != sel_valid_q) || (cur_valid && (cur_idx != sel_idx_q));
  end

  // Terminal count for the newly/currently selected note.
  always_comb begin
    half_m1 = CntW'(Half0 - 1);
    unique case (cur_idx)
      3'd0: half_m1 = CntW'(Half0 - 1);
      3'd1: half_m1 = CntW'(Half1 - 1);
      3'd2: half_m1 = CntW'(Half2 - 1);
      3'd3: half_m1 = CntW'(Half3 - 1);
      3'd4: half_m1 = CntW'(Half4 - 1);
      3'd5: half_m1 = CntW'(Half5 - 1);
      3'd6: half_m1 = CntW'(Half6 - 1);
      3'd7: half_m1 = CntW'(Half7 - 1);
      default: half_m1 = CntW'(Half0 - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_q <= 1'b0;
      sel_idx_q   <= 3'd0;
    end else begin
      sel_valid_q <= cur_valid;
      sel_idx_q   <= cur_idx;
    end
  end

  // Tone counter and speaker next state.
  always_comb begin
    cnt_d     = cnt_q;
    speaker_d = speaker_q;
    if (!cur_valid) begin
      cnt_d     = '0;
      speaker_d = 1'b0;
    end else if (sel_change) begin
      // The change cycle itself is phase 0 (count 0) of the new note, so the
      // register resumes at 1. The first rising edge then lands exactly HALF
      // cycles after the change cycle. Assumes every HALF is at least 2.
      cnt_d     = CntW'(1);
      speaker_d = 1'b0;
    end else if (cnt_q == half_m1) begin
      cnt_d     = '0;
      speaker_d = ~speaker_q;
    end else begin
      cnt_d     = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      speaker_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      speaker_q <= speaker_d;
    end
  end

  assign speaker = speaker_q;

endmodule

// File: tb/tb_music_notes_gen.sv
// Bench for music_notes_gen. A scoreboard queue holds every expected speaker
// transition (cycle number and new level); entries are pushed when switch stimulus is
// applied and popped when the monitor sees the speaker change. A reduced CLK_HZ
// keeps every note period short.

module tb_music_notes_gen;

  localparam int unsigned ClkHz = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] dip = 8'h00;
  logic       speaker;

  music_notes_gen #(
    .CLK_HZ(ClkHz)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dip_switches(dip),
    .speaker     (speaker)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        lvl;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Expected note model state: selected note, cycle of its phase-0, current level.
  logic        m_valid = 1'b0;
  int unsigned m_idx = 0;
  int unsigned m_s = 0;
  logic        m_lvl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned half(input int unsigned i);
    int unsigned f;
    case (i)
      0: f = 262;
      1: f = 294;
      2: f = 330;
      3: f = 349;
      4: f = 392;
      5: f = 440;
      6: f = 494;
      default: f = 523;
    endcase
    return ClkHz / (2 * f);
  endfunction

  function automatic void sel_of(input logic [7:0] d, output logic v, output int unsigned idx);
    v   = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i] && !v) begin
        v   = 1'b1;
        idx = i;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Monitor: every speaker transition must match the head of the scoreboard.
  logic prev_spk = 1'b0;
  always @(negedge clk) begin
    check("speaker_known", {31'b0, $isunknown(speaker)}, 32'd0);
    if (exp_q.size() > 0) begin
      check("edge_on_time", {31'b0, exp_q[0].cyc >= cyc}, 32'd1);
      if (exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    end
    if (speaker !== prev_spk) begin
      if (exp_q.size() == 0) begin
        check("edge_unexpected", {31'b0, speaker}, {31'b0, prev_spk});
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("edge_cycle", cyc, e.cyc);
        check("edge_level", {31'b0, speaker}, {31'b0, e.lvl});
      end
      prev_spk = speaker;
    end
  end

  // Apply switches at a falling edge (cycle k) and queue every transition expected in
  // cycles k+1..k+hold. The new selection is seen after edge k+2; at edge k+3 the
  // speaker is forced low and the new note's phase 0 is cycle k+2. hold must be >= 3.
  task automatic play(input logic [7:0] d, input int unsigned hold);
    int unsigned k;
    logic        nv;
    int unsigned ni;
    logic        changed;
    k = cyc;
    sel_of(d, nv, ni);
    changed = (nv != m_valid) || (nv && (ni != m_idx));
    for (int unsigned c = k + 1; c <= k + hold; c++) begin
      if (changed && (c == k + 3)) begin
        if (m_lvl) exp_q.push_back('{c, 1'b0});
        m_lvl   = 1'b0;
        m_valid = nv;
        m_idx   = ni;
        m_s     = k + 2;
      end else if (m_valid && (c > m_s) && (((c - m_s) % half(m_idx)) == 0)) begin
        m_lvl = ~m_lvl;
        exp_q.push_back('{c, m_lvl});
      end
    end
    dip = d;
    repeat (hold) @(negedge clk);
  endtask

  // Reset pulse 2 ns after a falling edge; the speaker must drop at once.
  task automatic reset_pulse(input int unsigned low_cycles, input logic [7:0] d,
                             input int unsigned hold);
    if (m_lvl) exp_q.push_back('{cyc + 1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_speaker", {31'b0, speaker}, 32'd0);
    check("async_reset_counter", 32'(dut.cnt_q), 32'd0);
    m_valid = 1'b0;
    m_lvl   = 1'b0;
    repeat (low_cycles) @(negedge clk);
    rst_n = 1'b1;
    play(d, hold);
  endtask

  initial begin
    // 1: reset held with C4 selected, then release.
    #1 rst_n = 1'b0;
    dip = 8'h01;
    repeat (3) @(negedge clk);
    check("reset_speaker", {31'b0, speaker}, 32'd0);
    check("reset_counter", 32'(dut.cnt_q), 32'd0);
    check("reset_sync2", {24'b0, dut.sync2_q}, 32'd0);
    rst_n = 1'b1;
    play(8'h01, half(0) + 10);
    check("c4_high_after_first_half", {31'b0, speaker}, 32'd1);

    // 2: A4, three half-periods.
    play(8'h20, 3 * half(5) + 20);

    // 3: C4 wins over C5, then C5 alone.
    play(8'h81, 2 * half(0) + 50);
    play(8'h80, 3 * half(7) + 10);

    // 4: fast walk, speaker stays low throughout.
    play(8'h00, 10);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h01 << i;
      play(w, 10);
      check("walk_speaker_low", {31'b0, speaker}, 32'd0);
    end
    play(8'h80, half(7) + 20);

    // 5: tone running, then silence within 3 clocks and held.
    play(8'h20, 1200);
    play(8'h00, 3);
    check("silent_speaker", {31'b0, speaker}, 32'd0);
    check("silent_counter", 32'(dut.cnt_q), 32'd0);
    play(8'h00, 100);
    check("silent_speaker_held", {31'b0, speaker}, 32'd0);
    check("silent_counter_held", 32'(dut.cnt_q), 32'd0);

    // Extra bits above the winning bit leave the phase undisturbed.
    play(8'h20, 1500);
    play(8'hE0, 1500);

    // 6: reset mid high half-period, then restart from phase 0.
    play(8'h20, half(5) + 300);
    check("pre_reset_high", {31'b0, speaker}, 32'd1);
    reset_pulse(3, 8'h20, 2 * half(5) + 20);

    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
